// File: rtl/pmax_pool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order feature map.
// One pixel per beat in, one pooled value per completed window out.
// The horizontal max of each pixel pair is kept in a half-row line buffer
// on even rows. On odd rows it is combined with the matching horizontal max.
module pmax_pool_2x2_stream #(
  parameter int DATA_W = 21,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  // Column counter is at least 2 bits so that col[CW-1:1] is always a legal slice.
  localparam int CW    = ($clog2(IMG_W) < 2) ? 2 : $clog2(IMG_W);
  localparam int RW    = ($clog2(IMG_H) < 1) ? 1 : $clog2(IMG_H);
  localparam int IW    = CW - 1;
  localparam int DEPTH = 1 << IW;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Full-width magnitude compare. Signedness is chosen at elaboration.
  // On a tie, b is returned. The two values are identical in that case.
  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic                     a_gt_b;
    sa = a;
    sb = b;
    if (SIGNED) a_gt_b = (sa > sb);
    else        a_gt_b = (a > b);
    return a_gt_b ? a : b;
  endfunction

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] hold_p0;
  logic [DATA_W-1:0] line_buf [DEPTH];
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] h_max;
  logic [DATA_W-1:0] v_max;
  logic              accept;
  logic              last_col;
  logic              last_row;

  // A new pixel can enter whenever the output register is empty or being drained.
  assign i_ready  = !o_valid || o_ready;
  // A flush overrides acceptance. The pixel presented in that cycle is dropped.
  assign accept   = i_valid && i_ready && !i_clear;
  assign idx      = col[CW-1:1];
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign h_max    = max2(hold_p0, i_data);
  assign v_max    = max2(line_buf[idx], h_max);

  // Raster position of the next pixel. Wraps seamlessly into the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (i_clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---- stage p0: capture the even-column pixel of each horizontal pair ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  hold_p0 <= '0;
    else if (accept && !col[0])  hold_p0 <= i_data;
  end

  // Even rows park the horizontal max. Every entry is written before it is read, so it is not reset.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) line_buf[idx] <= h_max;
  end

  // ---- stage p1: output register, loaded on the last pixel of each window ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (accept && col[0] && row[0]) begin
      o_data  <= v_max;
      o_valid <= 1'b1;
      o_last  <= last_row && last_col;
    end else if (o_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmax_pool_2x2_stream.sv
// Bench for pmax_pool_2x2_stream: unsigned and signed instances share one stimulus stream.
module tb_pmax_pool_2x2_stream;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam logic [63:0] F1 = 64'h09_07_00_04_02_03_05_01;
  localparam logic [63:0] F2 = 64'hFF_FF_80_80_01_FF_7F_80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready = 1'b1;
  logic          i_ready_u, i_ready_s, o_valid_u, o_valid_s, o_last_u, o_last_s;
  logic [DW-1:0] o_data_u, o_data_s;

  always #5 clk = ~clk;

  pmax_pool_2x2_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .i_ready(i_ready_u),
    .i_data(i_data), .o_valid(o_valid_u), .o_ready(o_ready), .o_data(o_data_u), .o_last(o_last_u));

  pmax_pool_2x2_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .i_ready(i_ready_s),
    .i_data(i_data), .o_valid(o_valid_s), .o_ready(o_ready), .o_data(o_data_s), .o_last(o_last_s));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the whole frame is stored, and each window max is taken over four stored pixels.
  logic [DW-1:0] frame [H][W];
  int pos = 0;
  int qu[$], qs[$], ql[$];
  int cap_u[$], cap_s[$], cap_l[$];
  bit stall_prev = 1'b0;
  int prev_u = 0;
  int prev_l = 0;

  function automatic int mx(input int a, input int b, input bit sgn);
    int x, y;
    x = a; y = b;
    if (sgn) begin
      if (x > 127) x -= 256;
      if (y > 127) y -= 256;
    end
    return (x > y) ? a : b;
  endfunction

  function automatic int win_max(input int r, input int c, input bit sgn);
    return mx(mx(int'(frame[r-1][c-1]), int'(frame[r-1][c]), sgn),
              mx(int'(frame[r][c-1]),   int'(frame[r][c]),   sgn), sgn);
  endfunction

  // Compare process: all outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pos = 0;
      qu.delete(); qs.delete(); ql.delete();
      stall_prev = 1'b0;
    end else begin
      chk("i_ready", int'(i_ready_u), int'(!o_valid_u || o_ready));
      chk("i_ready_s", int'(i_ready_s), int'(!o_valid_s || o_ready));
      chk("o_valid_u", int'(o_valid_u), int'(qu.size() != 0));
      chk("o_valid_s", int'(o_valid_s), int'(qs.size() != 0));
      if (stall_prev) begin
        chk("stall_data", int'(o_data_u), prev_u);
        chk("stall_last", int'(o_last_u), prev_l);
      end
      if (i_clear) begin
        pos = 0;
        qu.delete(); qs.delete(); ql.delete();
        stall_prev = 1'b0;
      end else begin
        stall_prev = o_valid_u && !o_ready;
        prev_u = int'(o_data_u);
        prev_l = int'(o_last_u);
        if (o_valid_u && o_ready && qu.size() > 0) begin
          chk("data_u", int'(o_data_u), qu[0]);
          chk("data_s", int'(o_data_s), qs[0]);
          chk("last_u", int'(o_last_u), ql[0]);
          chk("last_s", int'(o_last_s), ql[0]);
          cap_u.push_back(int'(o_data_u));
          cap_s.push_back(int'(o_data_s));
          cap_l.push_back(int'(o_last_u));
          void'(qu.pop_front()); void'(qs.pop_front()); void'(ql.pop_front());
        end
        if (i_valid && i_ready_u) begin
          int r, c;
          r = pos / W;
          c = pos % W;
          frame[r][c] = i_data;
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            qu.push_back(win_max(r, c, 1'b0));
            qs.push_back(win_max(r, c, 1'b1));
            ql.push_back(int'(r == H - 1 && c == W - 1));
          end
          pos = (pos + 1) % (W * H);
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] v);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    i_valid = 1'b1;
    i_data = v;
    while (!acc) begin
      @(negedge clk);
      acc = i_ready_u;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 100) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] px);
    for (int i = 0; i < 8; i++) push(px[8*i +: 8]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    o_ready = 1'b1;
    while ((qu.size() != 0 || o_valid_u) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_u.delete(); cap_s.delete(); cap_l.delete();
  endtask

  task automatic chk_seq(input string nm, input int n, input logic [31:0] eu,
                         input logic [31:0] es, input logic [3:0] el);
    chk($sformatf("%s_count", nm), cap_u.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < cap_u.size()) begin
        chk($sformatf("%s_u%0d", nm, i), cap_u[i], int'(eu[8*i +: 8]));
        chk($sformatf("%s_s%0d", nm, i), cap_s[i], int'(es[8*i +: 8]));
        chk($sformatf("%s_last%0d", nm, i), cap_l[i], int'(el[i]));
      end
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid_u && n < 100);
    if (!o_valid_u) chk(nm, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", int'(o_valid_u), 0);
    chk("rst_o_data", int'(o_data_u), 0);
    chk("rst_o_last", int'(o_last_u), 0);
    chk("rst_i_ready", int'(i_ready_u), 1);
    chk("rst_o_data_s", int'(o_data_s), 0);
    rst_n = 1'b1;

    // Test 1: basic unsigned/signed frame.
    clear_caps();
    send_frame(F1);
    drain();
    chk_seq("t1", 2, 32'h0905, 32'h0905, 4'b0010);

    // Test 2: signed versus unsigned compare at the extremes.
    clear_caps();
    send_frame(F2);
    drain();
    chk_seq("t2", 2, 32'hFF80, 32'h017F, 4'b0010);

    // Test 3: downstream stall holds the first result.
    clear_caps();
    o_ready = 1'b0;
    fork
      send_frame(F1);
      begin
        wait_valid("t3_wait");
        for (int k = 0; k < 5; k++) begin
          chk("t3_hold_data", int'(o_data_u), 8'h05);
          chk("t3_hold_iready", int'(i_ready_u), 0);
          @(posedge clk);
          if (k < 4) @(negedge clk);
        end
        #1;
        o_ready = 1'b1;
      end
    join
    drain();
    chk_seq("t3", 2, 32'h0905, 32'h0905, 4'b0010);

    // Test 4: two frames back to back.
    clear_caps();
    send_frame(F1);
    send_frame(F2);
    drain();
    chk_seq("t4", 4, 32'hFF80_0905, 32'h017F_0905, 4'b1010);

    // Test 5: flush after a partial frame.
    clear_caps();
    push(8'h33);
    push(8'h44);
    push(8'h55);
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_data = 8'hEE;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    send_frame(F1);
    drain();
    chk_seq("t5", 2, 32'h0905, 32'h0905, 4'b0010);

    // Test 6: asynchronous reset while a result is pending.
    clear_caps();
    o_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(F1[8*i +: 8]);
    wait_valid("t6_wait");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid_u", int'(o_valid_u), 0);
    chk("t6_async_valid_s", int'(o_valid_s), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    o_ready = 1'b1;
    send_frame(F1);
    drain();
    chk_seq("t6", 2, 32'h0905, 32'h0905, 4'b0010);

    // Randomized traffic with back-pressure and occasional flushes.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = DW'($urandom);
      o_ready = ($urandom_range(0, 3) != 0);
      i_clear = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    drain();
    chk("final_empty", qu.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
